projectile_bank: RTL and testbench
==================================

Name: projectile_bank

Overview:
Parametrised pool of NUM_SLOTS independent projectiles for both player lasers (DIR_UP=1) and invader bombs (DIR_UP=0). Allocates a free slot on a fire request, enforces a frame-based cooldown, and moves every live projectile by STEP pixels on each frame tick. Retires projectiles on collision or at the screen edge. Sits between the player/invader controllers and the collision/render logic, one instance per shooter class.

Parameters:
NUM_SLOTS, 4, number of concurrent projectiles (1..8)
COORD_W, 10, coordinate width in bits
DIR_UP, 1, 1 = y decreases each frame, 0 = y increases
STEP, 4, pixels moved per frame tick
START_Y, 400, y loaded on fire
X_OFFSET, 16, added to fire_x on fire (half scaled sprite width)
LIMIT_Y, 480, bottom bound used when DIR_UP=0 (top bound is 0)
COOLDOWN, 8, frame ticks after an accepted fire before the next fire is allowed (0 = none)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous game-restart clear, same effect as reset
frame  in  1  one-cycle frame tick
fire  in  1  fire request, level, sampled every cycle
fire_x  in  COORD_W  shooter x at time of request
hit  in  NUM_SLOTS  per-slot collision pulse
fire_ack  out  1  one-cycle pulse: request accepted this cycle
active  out  NUM_SLOTS  slot live flags
pos_x  out  NUM_SLOTS*COORD_W  packed x, slot i at [i*COORD_W +: COORD_W]
pos_y  out  NUM_SLOTS*COORD_W  packed y, same packing
num_active  out  4  population count of active

Behaviour:
- Reset (rst_n low, async) or clr (sync): active=0, pos_x=0, pos_y=0, fire_ack=0, cooldown counter=0, num_active=0. clr has priority over all other inputs in the same cycle.
- All outputs are registered. num_active is the popcount of the registered active, so it matches active in the same cycle.
- Accept condition, evaluated on registered state: fire=1 AND cooldown==0 AND at least one slot with active=0.
- On accept: the lowest-index free slot i gets active[i]=1, pos_x[i]=fire_x+X_OFFSET (truncated to COORD_W), pos_y[i]=START_Y. fire_ack=1 for that cycle. Cooldown is loaded with COOLDOWN.
- A request that is not accepted is dropped, not queued. fire_ack stays 0.
- Holding fire high produces one accept per cooldown expiry while slots are free.
- Cooldown decrements by 1 on each frame tick while nonzero. It is loaded, not decremented, when an accept and a frame tick occur in the same cycle.
- hit[i]=1 with active[i]=1 clears active[i] on that clock edge in any cycle. This has priority over movement. hit on an inactive slot is ignored.
- pos_x/pos_y of a retired slot hold their last value. Consumers must qualify them with active.
- On frame=1, for each slot that was active in the previous cycle and has no hit:
  - DIR_UP=1: if pos_y < STEP, retire the slot; else pos_y -= STEP.
  - DIR_UP=0: if pos_y + STEP >= LIMIT_Y (compare at COORD_W+1 bits), retire the slot; else pos_y += STEP.
  - pos_x never changes after allocation.
- Simultaneous fire and frame: the newly allocated slot keeps START_Y this frame and is not moved. Other slots move normally.
- A slot retired this cycle (hit or boundary) is not free for allocation until the next cycle. There is no same-cycle reuse.
- Latency: fire to active[i] and fire_ack is 1 cycle. frame to updated pos_y is 1 cycle.

Decomposition:
- Shared constants package: screen width/height, SPRITE_WIDTH_SCALED, PLAYER_START_Y, LASER_STEP, BOMB_STEP, default cooldowns. Instances bind START_Y/STEP/X_OFFSET from these.
- Sub-module projectile_slot: one slot holding active, x and y, with load/hit/frame inputs and the boundary compare.
- The bank contains the generate array of slots, the lowest-free priority encoder, the cooldown counter and the popcount.

Test Plan:
- Reset/clr: drive rst_n low mid-flight with 3 slots live -> all outputs 0 immediately. Repeat with clr=1 for one cycle -> all 0 after the edge.
- Single shot, DIR_UP=1, START_Y=400, STEP=4, fire_x=100 -> slot0 x=116 y=400, fire_ack one cycle. After 100 frames y=0. Frame 101 retires it. num_active goes 1 -> 0.
- Cooldown/fill: COOLDOWN=8, fire held high for 40 frames -> accepts at frames 0, 8, 16, 24 into slots 0..3. The request at frame 32 is dropped while 4 slots are live.
- Hit priority: hit[1] and frame in the same cycle on a live slot1 at y=200 -> active[1]=0, pos_y[1] stays 200. hit[2] on an idle slot -> no change.
- Same-cycle fire+frame: slot0 live at y=300, fire and frame together -> slot0 y=296, slot1 allocated at y=400. The next frame gives slot1 y=396.
- DIR_UP=0, LIMIT_Y=480, START_Y=40, STEP=8 -> y steps 48..472. The frame at y=472 retires the slot (472+8>=480). Lowest-free reuse: free slot0 while slots 1-2 are live -> the next accept goes to slot0.

Source files
------------

// File: rtl/projectile_bank_pkg.sv
// rtl/projectile_bank_pkg.sv - shared screen/sprite constants and helpers for projectile banks
package projectile_bank_pkg;

  localparam int SCREEN_W            = 640;
  localparam int SCREEN_H            = 480;
  localparam int SPRITE_WIDTH_SCALED = 32;
  localparam int PLAYER_START_Y      = 400;
  localparam int LASER_STEP          = 4;
  localparam int BOMB_STEP           = 8;
  localparam int LASER_COOLDOWN      = 8;
  localparam int BOMB_COOLDOWN       = 0;
  localparam int MAX_SLOTS           = 8;

  typedef enum logic [1:0] {
    EV_IDLE   = 2'd0,
    EV_LOAD   = 2'd1,
    EV_RETIRE = 2'd2,
    EV_MOVE   = 2'd3
  } slot_ev_e;

  function automatic logic [3:0] popcount8(input logic [MAX_SLOTS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/projectile_slot.sv
// rtl/projectile_slot.sv - one projectile: live flag, x/y registers and screen-edge retire check
module projectile_slot
  import projectile_bank_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int DIR_UP  = 1,
  parameter int STEP    = 4,
  parameter int START_Y = 400,
  parameter int LIMIT_Y = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic               hit,
  input  logic               frame,
  output logic               active,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y
);

  localparam logic [COORD_W:0]   STEP_E  = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   LIMIT_E = (COORD_W+1)'(LIMIT_Y);
  localparam logic [COORD_W-1:0] START_V = COORD_W'(START_Y);

  logic [COORD_W:0]   y_ext;
  logic [COORD_W:0]   y_sum;
  logic [COORD_W-1:0] y_dec;
  logic [COORD_W-1:0] y_next;
  logic               at_edge;
  slot_ev_e           ev;

  // One extra bit so the downward bound compare cannot wrap.
  assign y_ext = {1'b0, pos_y};
  assign y_sum = y_ext + STEP_E;
  assign y_dec = pos_y - STEP_E[COORD_W-1:0];

  always_comb begin
    at_edge = 1'b0;
    y_next  = pos_y;
    if (DIR_UP != 0) begin
      at_edge = (y_ext < STEP_E);
      y_next  = y_dec;
    end else begin
      at_edge = (y_sum >= LIMIT_E);
      y_next  = y_sum[COORD_W-1:0];
    end
  end

  // The bank only loads free slots, so load never races a hit on live state.
  always_comb begin
    ev = EV_IDLE;
    if (load) begin
      ev = EV_LOAD;
    end else if (active && hit) begin
      ev = EV_RETIRE;
    end else if (active && frame) begin
      ev = at_edge ? EV_RETIRE : EV_MOVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      pos_x  <= '0;
      pos_y  <= '0;
    end else if (clr) begin
      active <= 1'b0;
      pos_x  <= '0;
      pos_y  <= '0;
    end else begin
      case (ev)
        EV_LOAD: begin
          active <= 1'b1;
          pos_x  <= load_x;
          pos_y  <= START_V;
        end
        EV_RETIRE: active <= 1'b0;
        EV_MOVE:   pos_y  <= y_next;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/projectile_bank.sv
// rtl/projectile_bank.sv - pool of projectile slots with lowest-free allocation and frame cooldown
module projectile_bank
  import projectile_bank_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int COORD_W   = 10,
  parameter int DIR_UP    = 1,
  parameter int STEP      = LASER_STEP,
  parameter int START_Y   = PLAYER_START_Y,
  parameter int X_OFFSET  = SPRITE_WIDTH_SCALED / 2,
  parameter int LIMIT_Y   = SCREEN_H,
  parameter int COOLDOWN  = LASER_COOLDOWN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         frame,
  input  logic                         fire,
  input  logic [COORD_W-1:0]           fire_x,
  input  logic [NUM_SLOTS-1:0]         hit,
  output logic                         fire_ack,
  output logic [NUM_SLOTS-1:0]         active,
  output logic [NUM_SLOTS*COORD_W-1:0] pos_x,
  output logic [NUM_SLOTS*COORD_W-1:0] pos_y,
  output logic [3:0]                   num_active
);

  localparam int              CD_W    = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [CD_W-1:0]      cd;
  logic [NUM_SLOTS-1:0] free_sel;
  logic [NUM_SLOTS-1:0] load_vec;
  logic                 any_free;
  logic                 accept;
  logic [COORD_W-1:0]   load_x;
  logic [MAX_SLOTS-1:0] act_ext;

  // Lowest-index free slot; a slot retired this edge still reads active here.
  always_comb begin
    free_sel = '0;
    any_free = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!active[i] && !any_free) begin
        free_sel[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
  end

  assign accept   = fire && (cd == '0) && any_free;
  assign load_vec = accept ? free_sel : '0;
  assign load_x   = fire_x + COORD_W'(X_OFFSET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_ack <= 1'b0;
      cd       <= '0;
    end else if (clr) begin
      fire_ack <= 1'b0;
      cd       <= '0;
    end else begin
      fire_ack <= accept;
      if (accept) begin
        cd <= CD_LOAD;
      end else if (frame && (cd != '0)) begin
        cd <= cd - 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
      projectile_slot #(
        .COORD_W (COORD_W),
        .DIR_UP  (DIR_UP),
        .STEP    (STEP),
        .START_Y (START_Y),
        .LIMIT_Y (LIMIT_Y)
      ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .load   (load_vec[g]),
        .load_x (load_x),
        .hit    (hit[g]),
        .frame  (frame),
        .active (active[g]),
        .pos_x  (pos_x[g*COORD_W +: COORD_W]),
        .pos_y  (pos_y[g*COORD_W +: COORD_W])
      );
    end
  endgenerate

  assign act_ext    = MAX_SLOTS'(active);
  assign num_active = popcount8(act_ext);

endmodule

// File: tb/tb_projectile_bank.sv
// tb/tb_projectile_bank.sv - scoreboard bench for an upward laser bank and a downward bomb bank
module tb_projectile_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        fire_u = 1'b0, frame_u = 1'b0, fire_d = 1'b0, frame_d = 1'b0;
  logic [9:0]  fx_u = '0, fx_d = '0;
  logic [3:0]  hit_u = '0, hit_d = '0;
  logic        ack_u, ack_d;
  logic [3:0]  act_u, act_d, num_u, num_d;
  logic [39:0] px_u, py_u, px_d, py_d;

  projectile_bank #(
    .NUM_SLOTS(4), .COORD_W(10), .DIR_UP(1), .STEP(4), .START_Y(400),
    .X_OFFSET(16), .LIMIT_Y(480), .COOLDOWN(8)
  ) dut_up (
    .clk(clk), .rst_n(rst_n), .clr(clr), .frame(frame_u), .fire(fire_u),
    .fire_x(fx_u), .hit(hit_u), .fire_ack(ack_u), .active(act_u),
    .pos_x(px_u), .pos_y(py_u), .num_active(num_u)
  );

  projectile_bank #(
    .NUM_SLOTS(4), .COORD_W(10), .DIR_UP(0), .STEP(8), .START_Y(40),
    .X_OFFSET(16), .LIMIT_Y(480), .COOLDOWN(0)
  ) dut_dn (
    .clk(clk), .rst_n(rst_n), .clr(clr), .frame(frame_d), .fire(fire_d),
    .fire_x(fx_d), .hit(hit_d), .fire_ack(ack_d), .active(act_d),
    .pos_x(px_d), .pos_y(py_d), .num_active(num_d)
  );

  typedef struct {
    int d;
    int slot;
    int x;
    int y;
  } ack_t;

  typedef struct {
    int    d;
    string nm;
    int    act;
    int    numa;
    int    slot;
    int    x;
    int    y;
    bit    zero;
  } snap_t;

  ack_t  q_ack_u[$];
  ack_t  q_ack_d[$];
  snap_t q_snap[$];
  int    tests = 0;
  int    fails = 0;
  logic  chk = 1'b0;

  task automatic cmp(input string nm, input int actual, input int expv);
    tests++;
    if (actual != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, actual, expv);
    end
  endtask

  task automatic check_ack(input int d);
    ack_t        e;
    logic [3:0]  a;
    logic [39:0] px, py;
    a  = (d != 0) ? act_d : act_u;
    px = (d != 0) ? px_d : px_u;
    py = (d != 0) ? py_d : py_u;
    if ((d == 0 && q_ack_u.size() == 0) || (d != 0 && q_ack_d.size() == 0)) begin
      cmp($sformatf("unexpected_ack_dut%0d", d), 1, 0);
      return;
    end
    e = (d != 0) ? q_ack_d.pop_front() : q_ack_u.pop_front();
    cmp($sformatf("ack_dut%0d_slot%0d_active", d, e.slot), int'(a[e.slot]), 1);
    cmp($sformatf("ack_dut%0d_slot%0d_x", d, e.slot), int'(px[e.slot*10 +: 10]), e.x);
    cmp($sformatf("ack_dut%0d_slot%0d_y", d, e.slot), int'(py[e.slot*10 +: 10]), e.y);
  endtask

  task automatic check_snap();
    snap_t       s;
    logic [3:0]  a, n;
    logic [39:0] px, py;
    logic        k;
    if (q_snap.size() == 0) begin
      cmp("snap_queue_underflow", 0, 1);
      return;
    end
    s  = q_snap.pop_front();
    a  = (s.d != 0) ? act_d : act_u;
    n  = (s.d != 0) ? num_d : num_u;
    px = (s.d != 0) ? px_d : px_u;
    py = (s.d != 0) ? py_d : py_u;
    k  = (s.d != 0) ? ack_d : ack_u;
    cmp({s.nm, "_active"}, int'(a), s.act);
    cmp({s.nm, "_num_active"}, int'(n), s.numa);
    if (s.slot >= 0) begin
      cmp({s.nm, "_x"}, int'(px[s.slot*10 +: 10]), s.x);
      cmp({s.nm, "_y"}, int'(py[s.slot*10 +: 10]), s.y);
    end
    if (s.zero) begin
      cmp({s.nm, "_pos_x_nonzero"}, int'(px != '0), 0);
      cmp({s.nm, "_pos_y_nonzero"}, int'(py != '0), 0);
      cmp({s.nm, "_fire_ack"}, int'(k), 0);
    end
  endtask

  // Monitor: consumes expectations whenever the DUTs present an ack or a check strobe.
  always @(negedge clk) begin
    if (ack_u) check_ack(0);
    if (ack_d) check_ack(1);
    if (chk) check_snap();
  end

  task automatic step(input int d, input int f, input int fr, input int h, input int x);
    if (d == 0) begin
      fire_u = (f != 0); frame_u = (fr != 0); hit_u = h[3:0]; fx_u = x[9:0];
    end else begin
      fire_d = (f != 0); frame_d = (fr != 0); hit_d = h[3:0]; fx_d = x[9:0];
    end
    @(posedge clk);
    #1;
    fire_u = 1'b0; frame_u = 1'b0; hit_u = '0;
    fire_d = 1'b0; frame_d = 1'b0; hit_d = '0;
  endtask

  task automatic frames(input int d, input int n);
    repeat (n) step(d, 0, 1, 0, 0);
  endtask

  task automatic exp_ack(input int d, input int slot, input int x, input int y);
    ack_t e;
    e.d = d; e.slot = slot; e.x = x; e.y = y;
    if (d != 0) q_ack_d.push_back(e);
    else q_ack_u.push_back(e);
  endtask

  task automatic snap(input int d, input string nm, input int act, input int numa,
                      input int slot, input int x, input int y, input bit zero);
    snap_t s;
    s.d = d; s.nm = nm; s.act = act; s.numa = numa;
    s.slot = slot; s.x = x; s.y = y; s.zero = zero;
    q_snap.push_back(s);
    chk = 1'b1;
    @(negedge clk);
    #1;
    chk = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap(0, "reset_up", 0, 0, -1, 0, 0, 1'b1);
    snap(1, "reset_dn", 0, 0, -1, 0, 0, 1'b1);

    // Single upward shot from 400 to the top edge and retirement.
    exp_ack(0, 0, 116, 400);
    step(0, 1, 0, 0, 100);
    snap(0, "shot_live", 1, 1, 0, 116, 400, 1'b0);
    frames(0, 100);
    snap(0, "shot_y0", 1, 1, 0, 116, 0, 1'b0);
    frames(0, 1);
    snap(0, "shot_retired", 0, 0, 0, 116, 0, 1'b0);

    // Same-cycle fire and frame.
    exp_ack(0, 0, 26, 400);
    step(0, 1, 0, 0, 10);
    frames(0, 25);
    snap(0, "ff_pre", 1, 1, 0, 26, 300, 1'b0);
    exp_ack(0, 1, 66, 400);
    step(0, 1, 1, 0, 50);
    snap(0, "ff_slot0", 3, 2, 0, 26, 296, 1'b0);
    snap(0, "ff_slot1", 3, 2, 1, 66, 400, 1'b0);
    frames(0, 1);
    snap(0, "ff_next", 3, 2, 1, 66, 396, 1'b0);

    // Hit beats frame movement; hit on an idle slot is ignored.
    frames(0, 49);
    snap(0, "pre_hit", 3, 2, 1, 66, 200, 1'b0);
    step(0, 0, 1, 4'b0010, 0);
    snap(0, "hit1", 1, 1, 1, 66, 200, 1'b0);
    snap(0, "hit1_slot0", 1, 1, 0, 26, 92, 1'b0);
    step(0, 0, 0, 4'b0100, 0);
    snap(0, "hit_idle", 1, 1, 0, 26, 92, 1'b0);

    // clr right after an accept, with fire held in the clr cycle.
    exp_ack(0, 1, 16, 400);
    step(0, 1, 0, 0, 0);
    clr = 1'b1;
    step(0, 1, 1, 0, 0);
    clr = 1'b0;
    snap(0, "clr", 0, 0, -1, 0, 0, 1'b1);

    // Fire held high, frame every other cycle: four accepts, then full.
    for (int s = 0; s < 4; s++) exp_ack(0, s, 216, 400);
    for (int c = 0; c < 80; c++) step(0, 1, (c % 2 == 0) ? 1 : 0, 0, 200);
    snap(0, "fill_s0", 15, 4, 0, 216, 244, 1'b0);
    snap(0, "fill_s1", 15, 4, 1, 216, 276, 1'b0);
    snap(0, "fill_s3", 15, 4, 3, 216, 340, 1'b0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    snap(0, "async_rst", 0, 0, -1, 0, 0, 1'b1);
    rst_n = 1'b1;

    // Downward bank: 40 -> 472 in steps of 8, retired on the next frame.
    exp_ack(1, 0, 16, 40);
    step(1, 1, 0, 0, 0);
    snap(1, "dn_live", 1, 1, 0, 16, 40, 1'b0);
    frames(1, 1);
    snap(1, "dn_48", 1, 1, 0, 16, 48, 1'b0);
    frames(1, 53);
    snap(1, "dn_472", 1, 1, 0, 16, 472, 1'b0);
    frames(1, 1);
    snap(1, "dn_retired", 0, 0, 0, 16, 472, 1'b0);

    // Lowest-free reuse, x truncation, and no same-cycle reuse of a hit slot.
    exp_ack(1, 0, 12, 40); step(1, 1, 0, 0, 1020);
    exp_ack(1, 1, 12, 40); step(1, 1, 0, 0, 1020);
    exp_ack(1, 2, 12, 40); step(1, 1, 0, 0, 1020);
    snap(1, "dn_three", 7, 3, 2, 12, 40, 1'b0);
    step(1, 0, 0, 4'b0001, 0);
    snap(1, "dn_free0", 6, 2, -1, 0, 0, 1'b0);
    exp_ack(1, 0, 30, 40); step(1, 1, 0, 0, 14);
    exp_ack(1, 3, 21, 40); step(1, 1, 0, 0, 5);
    snap(1, "dn_full", 15, 4, 0, 30, 40, 1'b0);
    step(1, 1, 0, 4'b0100, 100);
    snap(1, "dn_no_reuse", 11, 3, -1, 0, 0, 1'b0);
    exp_ack(1, 2, 116, 40); step(1, 1, 0, 0, 100);
    snap(1, "dn_reuse2", 15, 4, 2, 116, 40, 1'b0);
    step(1, 1, 0, 0, 0);
    snap(1, "dn_drop_full", 15, 4, 3, 21, 40, 1'b0);

    cmp("ack_queue_up_left", q_ack_u.size(), 0);
    cmp("ack_queue_dn_left", q_ack_d.size(), 0);
    cmp("snap_queue_left", q_snap.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
